cpu_rom_fetch: RTL and testbench
================================

CPU_ROM_FETCH -- requirements
Module: cpu_rom_fetch

Interface
REQ-001 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port mem_rd  in  1  one-cycle CPU read strobe marking the start of a bus read.
REQ-004 SHALL have port cpu_rom_memrq  in  1  decoder select: the current CPU address lies in ROM space.
REQ-005 SHALL have port sdr_addr  in  25  decoded SDRAM byte address of the CPU access.
REQ-006 SHALL have port flush  in  1  single-cycle request to invalidate the buffer, asserted on a bank_select change.
REQ-007 SHALL have port cpu_dout  out  16  read data returned to the CPU.
REQ-008 SHALL have port cpu_ready  out  1  high when no fetch is outstanding; low stalls the CPU.
REQ-009 SHALL have port sdr_req  out  1  toggle-type SDRAM request.
REQ-010 SHALL have port sdr_ack  in  1  toggle-type SDRAM acknowledge; equals sdr_req when the transfer is complete.
REQ-011 SHALL have port sdr_rom_addr  out  25  SDRAM line address, always 8-byte aligned (bits [2:0] = 0).
REQ-012 SHALL have port sdr_data  in  64  SDRAM line data, valid in the cycle the acknowledge matches.

Function
REQ-013 SHALL hold two direct-mapped line entries of 64 bits, indexed by sdr_addr[3], each with tag sdr_addr[24:4] and a valid bit.
REQ-014 SHALL select the returned word with sdr_addr[2:1]: word 0 = data[15:0], up to word 3 = data[63:48].
REQ-015 SHALL implement exactly two states, IDLE and WAIT.
REQ-016 SHALL treat mem_rd with cpu_rom_memrq=0 as no-op in every state.
REQ-017 In IDLE, a hit (mem_rd & memrq & entry valid & tag equal) SHALL load cpu_dout at the next edge, keep cpu_ready=1 and stay in IDLE (1-cycle latency, no SDRAM traffic).
REQ-018 In IDLE, a miss SHALL, at the next edge, drive sdr_rom_addr={sdr_addr[24:3],3'b0}, toggle sdr_req, drive cpu_ready=0, latch index/tag/word-select and enter WAIT.
REQ-019 In WAIT, when sdr_ack==sdr_req, at that edge the block SHALL:
  - write sdr_data into the latched entry;
  - set the tag and (per REQ-021) the valid bit;
  - load cpu_dout with the selected word;
  - set cpu_ready=1 and return to IDLE.
REQ-020 In WAIT, mem_rd SHALL be ignored; only one request SHALL ever be outstanding.
REQ-021 flush SHALL clear both valid bits at the next edge; if flush occurs during WAIT or in the completion cycle, the filled line SHALL still be returned to the CPU but SHALL NOT be marked valid.
REQ-022 flush coincident with a hit in IDLE SHALL be treated as a miss.
REQ-023 sdr_req SHALL toggle only on the IDLE->WAIT transition; sdr_rom_addr SHALL be stable throughout WAIT.
REQ-024 A fill to one index SHALL NOT disturb the other entry.

Reset
REQ-025 On reset, asynchronously:
  - state = IDLE;
  - cpu_ready = 1, cpu_dout = 0;
  - sdr_req = 0, sdr_rom_addr = 0;
  - both valid bits = 0 (tags and data unspecified).
REQ-026 Reset asserted during WAIT SHALL abandon the fetch; after release, a late acknowledge toggle SHALL NOT alter any entry or output until the next miss.

Verification
REQ-027 Miss then hit:
  - read 0x0012346 -> sdr_rom_addr=0x0012340, sdr_req toggles, cpu_ready=0;
  - ack with data 0x4444_3333_2222_1111 -> cpu_dout=0x4444, cpu_ready=1;
  - read 0x0012342 -> cpu_dout=0x2222 next cycle, no sdr_req toggle.
REQ-028 Two indexes: fill 0x0012340, then fill 0x0012348 -> both re-reads hit with no SDRAM request.
REQ-029 Tag conflict: after fill 0x0012340, read 0x0022340 -> miss, same index replaced; a re-read of 0x0012340 then misses.
REQ-030 flush during WAIT: data returned to the CPU, cpu_ready=1; the same address re-read -> miss.
REQ-031 Ignored strobes:
  - mem_rd with memrq=0 -> no state change;
  - mem_rd during WAIT -> no extra sdr_req toggle.
REQ-032 Reset during WAIT -> cpu_ready=1, sdr_req=0 at once; a subsequent read of the same address -> miss.

Source files
------------

// File: rtl/cpu_rom_fetch_if.sv
// CPU-side strobe/data and SDRAM-side toggle handshake of the ROM fetch buffer.
interface cpu_rom_fetch_if;
    logic        mem_rd;
    logic        cpu_rom_memrq;
    logic [24:0] sdr_addr;
    logic        flush;
    logic [15:0] cpu_dout;
    logic        cpu_ready;
    logic        sdr_req;
    logic        sdr_ack;
    logic [24:0] sdr_rom_addr;
    logic [63:0] sdr_data;

    // Environment side: the CPU plus the SDRAM controller.
    modport master (
        output mem_rd, cpu_rom_memrq, sdr_addr, flush, sdr_ack, sdr_data,
        input  cpu_dout, cpu_ready, sdr_req, sdr_rom_addr
    );

    // The fetch buffer itself.
    modport slave (
        input  mem_rd, cpu_rom_memrq, sdr_addr, flush, sdr_ack, sdr_data,
        output cpu_dout, cpu_ready, sdr_req, sdr_rom_addr
    );
endinterface

// File: rtl/cpu_rom_fetch.sv
// Two-entry direct-mapped 64-bit line buffer between the CPU ROM reads and
// a toggle-handshake SDRAM port. Hits return in one cycle; misses stall the
// CPU until the line arrives.
module cpu_rom_fetch (
    input  logic             clk,
    input  logic             reset,
    cpu_rom_fetch_if.slave   bus
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state;
    logic [1:0]  valid;
    logic [20:0] tag_mem  [2];
    logic [63:0] line_mem [2];

    // Miss context held for the duration of the fetch.
    logic        idx_q;
    logic [20:0] tag_q;
    logic [1:0]  word_q;
    logic        flushed_q;   // a flush was seen after the miss: do not validate the fill

    logic        idx;
    logic [20:0] tag_in;
    logic [1:0]  word_in;
    logic        strobe;
    logic        hit;
    logic        miss;
    logic        done;

    assign idx     = bus.sdr_addr[3];
    assign tag_in  = bus.sdr_addr[24:4];
    assign word_in = bus.sdr_addr[2:1];
    assign strobe  = bus.mem_rd & bus.cpu_rom_memrq;
    // A flush in the same cycle invalidates the line before it could be used.
    assign hit     = strobe & valid[idx] & (tag_mem[idx] == tag_in) & ~bus.flush;
    assign miss    = strobe & ~hit;
    assign done    = (state == WAIT) & (bus.sdr_ack == bus.sdr_req);

    function automatic logic [15:0] sel_word(input logic [63:0] d, input logic [1:0] w);
        return d[{w, 4'b0000} +: 16];
    endfunction

    // Control FSM with registered CPU and SDRAM-request outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            valid            <= 2'b00;
            bus.cpu_dout     <= 16'h0000;
            bus.cpu_ready    <= 1'b1;
            bus.sdr_req      <= 1'b0;
            bus.sdr_rom_addr <= 25'd0;
            idx_q            <= 1'b0;
            tag_q            <= 21'd0;
            word_q           <= 2'b00;
            flushed_q        <= 1'b0;
        end else begin
            if (bus.flush)
                valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (hit) begin
                        bus.cpu_dout <= sel_word(line_mem[idx], word_in);
                    end else if (miss) begin
                        bus.sdr_rom_addr <= {bus.sdr_addr[24:3], 3'b000};
                        bus.sdr_req      <= ~bus.sdr_req;
                        bus.cpu_ready    <= 1'b0;
                        idx_q            <= idx;
                        tag_q            <= tag_in;
                        word_q           <= word_in;
                        flushed_q        <= bus.flush;
                        state            <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.flush)
                        flushed_q <= 1'b1;
                    if (done) begin
                        // Overrides the flush clear above for this entry only when no flush was seen.
                        valid[idx_q]  <= ~(flushed_q | bus.flush);
                        bus.cpu_dout  <= sel_word(bus.sdr_data, word_q);
                        bus.cpu_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (done) begin
            line_mem[idx_q] <= bus.sdr_data;
            tag_mem[idx_q]  <= tag_q;
        end
    end
endmodule

// File: tb/tb_cpu_rom_fetch.sv
// Directed bench for cpu_rom_fetch: a transaction-level buffer model checked
// every cycle, plus hand-computed expectations at key points.
module tb_cpu_rom_fetch;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cpu_rom_fetch_if bus();

    cpu_rom_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] D1 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] D2 = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] D3 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D4 = 64'h1357_9BDF_2468_ACE0;
    localparam logic [63:0] D5 = 64'hFEDC_BA98_7654_3210;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Two lines, each {valid, tag, data}; one pending fetch remembered by address.
    bit          m_valid [2];
    logic [20:0] m_tag   [2];
    logic [63:0] m_line  [2];
    bit          pending   = 0;
    logic [24:0] p_addr    = '0;
    bit          p_flushed = 0;
    logic [15:0] exp_dout  = '0;
    logic        exp_ready = 1'b1;
    logic        exp_req   = 1'b0;
    logic [24:0] exp_addr  = '0;
    int          mi;
    int          mw;

    // Model advances on every clock edge from the stimulus it was given.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   = 0;
            m_valid[0] = 0;
            m_valid[1] = 0;
            exp_dout  = '0;
            exp_ready = 1'b1;
            exp_req   = 1'b0;
            exp_addr  = '0;
        end else begin
            if (bus.flush) begin
                m_valid[0] = 0;
                m_valid[1] = 0;
            end
            if (!pending) begin
                if (bus.mem_rd && bus.cpu_rom_memrq) begin
                    mi = int'(bus.sdr_addr[3]);
                    mw = int'(bus.sdr_addr[2:1]);
                    if (!bus.flush && m_valid[mi] && m_tag[mi] == bus.sdr_addr[24:4]) begin
                        exp_dout = m_line[mi][16*mw +: 16];
                    end else begin
                        pending   = 1;
                        p_addr    = bus.sdr_addr;
                        p_flushed = bus.flush;
                        exp_req   = ~exp_req;
                        exp_addr  = {bus.sdr_addr[24:3], 3'b000};
                        exp_ready = 1'b0;
                    end
                end
            end else if (bus.sdr_ack === exp_req) begin
                mi = int'(p_addr[3]);
                mw = int'(p_addr[2:1]);
                m_line[mi]  = bus.sdr_data;
                m_tag[mi]   = p_addr[24:4];
                m_valid[mi] = !(p_flushed || bus.flush);
                exp_dout    = bus.sdr_data[16*mw +: 16];
                exp_ready   = 1'b1;
                pending     = 0;
            end else if (bus.flush) begin
                p_flushed = 1;
            end
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("cyc_dout",  {48'd0, bus.cpu_dout},     {48'd0, exp_dout});
            chk("cyc_ready", {63'd0, bus.cpu_ready},    {63'd0, exp_ready});
            chk("cyc_req",   {63'd0, bus.sdr_req},      {63'd0, exp_req});
            chk("cyc_addr",  {39'd0, bus.sdr_rom_addr}, {39'd0, exp_addr});
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_read(input logic [24:0] a, input bit rq = 1'b1, input bit fl = 1'b0);
        @(negedge clk);
        bus.mem_rd        = 1'b1;
        bus.cpu_rom_memrq = rq;
        bus.sdr_addr      = a;
        bus.flush         = fl;
        @(negedge clk);
        bus.mem_rd        = 1'b0;
        bus.cpu_rom_memrq = 1'b0;
        bus.flush         = 1'b0;
    endtask

    task automatic do_ack(input logic [63:0] d);
        int n = 0;
        while (bus.sdr_req == bus.sdr_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.sdr_req == bus.sdr_ack) begin
            checks++;
            errors++;
            $display("FAIL ack_wait no sdr_req toggle seen within 20 cycles t=%0t", $time);
        end
        bus.sdr_data = d;
        bus.sdr_ack  = ~bus.sdr_ack;
        @(negedge clk);
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    initial begin
        bus.mem_rd        = 1'b0;
        bus.cpu_rom_memrq = 1'b0;
        bus.sdr_addr      = '0;
        bus.flush         = 1'b0;
        bus.sdr_ack       = 1'b0;
        bus.sdr_data      = '0;

        #12;
        chk("rst_ready", {63'd0, bus.cpu_ready},    64'd1);
        chk("rst_dout",  {48'd0, bus.cpu_dout},     64'd0);
        chk("rst_req",   {63'd0, bus.sdr_req},      64'd0);
        chk("rst_addr",  {39'd0, bus.sdr_rom_addr}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Miss then hit.
        do_read(25'h0012346);
        chk("miss_addr",  {39'd0, bus.sdr_rom_addr}, 64'h0012340);
        chk("miss_req",   {63'd0, bus.sdr_req},      64'd1);
        chk("miss_ready", {63'd0, bus.cpu_ready},    64'd0);
        do_ack(D1);
        chk("fill_dout",  {48'd0, bus.cpu_dout},  64'h4444);
        chk("fill_ready", {63'd0, bus.cpu_ready}, 64'd1);
        do_read(25'h0012342);
        chk("hit_dout", {48'd0, bus.cpu_dout}, 64'h2222);
        chk("hit_req",  {63'd0, bus.sdr_req},  64'd1);

        // Second index filled, both stay resident.
        do_read(25'h0012348);
        chk("idx1_miss", {63'd0, bus.cpu_ready}, 64'd0);
        do_ack(D2);
        chk("idx1_dout", {48'd0, bus.cpu_dout}, 64'hDDDD);
        do_read(25'h0012340);
        chk("idx0_hit",  {48'd0, bus.cpu_dout}, 64'h1111);
        do_read(25'h001234E);
        chk("idx1_hit",  {48'd0, bus.cpu_dout}, 64'hAAAA);
        chk("idx_noreq", {63'd0, bus.sdr_req},  64'd0);

        // Tag conflict replaces index 0 only.
        do_read(25'h0022340);
        chk("conf_miss", {63'd0, bus.cpu_ready}, 64'd0);
        do_ack(D3);
        chk("conf_dout", {48'd0, bus.cpu_dout}, 64'hCDEF);
        do_read(25'h0012340);
        chk("evict_miss", {63'd0, bus.cpu_ready}, 64'd0);
        do_ack(D1);
        chk("evict_dout", {48'd0, bus.cpu_dout}, 64'h1111);
        do_read(25'h001234A);
        chk("other_hit", {48'd0, bus.cpu_dout},  64'hCCCC);
        chk("other_rdy", {63'd0, bus.cpu_ready}, 64'd1);

        // Ignored strobes.
        do_read(25'h0033340, 1'b0);
        chk("nomemrq_dout", {48'd0, bus.cpu_dout}, 64'hCCCC);
        chk("nomemrq_req",  {63'd0, bus.sdr_req},  64'd0);
        do_read(25'h0044440);
        chk("w_req", {63'd0, bus.sdr_req}, 64'd1);
        do_read(25'h0055558);
        chk("w_req_hold",  {63'd0, bus.sdr_req},      64'd1);
        chk("w_addr_hold", {39'd0, bus.sdr_rom_addr}, 64'h0044440);
        do_ack(D4);
        chk("w_dout", {48'd0, bus.cpu_dout}, 64'hACE0);

        // Flush during WAIT: data delivered, line left invalid.
        do_read(25'h0066660);
        pulse_flush();
        do_ack(D5);
        chk("fl_dout",  {48'd0, bus.cpu_dout},  64'h3210);
        chk("fl_ready", {63'd0, bus.cpu_ready}, 64'd1);
        do_read(25'h0066660);
        chk("fl_remiss", {63'd0, bus.cpu_ready}, 64'd0);
        do_ack(D5);
        do_read(25'h001234A);
        chk("fl_other_miss", {63'd0, bus.cpu_ready}, 64'd0);
        do_ack(D2);
        chk("fl_other_dout", {48'd0, bus.cpu_dout}, 64'hCCCC);

        // Flush coincident with what would be a hit.
        do_read(25'h0066662, 1'b1, 1'b1);
        chk("flhit_miss", {63'd0, bus.cpu_ready}, 64'd0);
        do_ack(D5);
        chk("flhit_dout", {48'd0, bus.cpu_dout}, 64'h7654);

        // Reset during WAIT abandons the fetch.
        do_read(25'h0012340);
        chk("rw_miss", {63'd0, bus.cpu_ready}, 64'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        bus.sdr_ack = 1'b0;
        #1;
        chk("rw_ready", {63'd0, bus.cpu_ready}, 64'd1);
        chk("rw_req",   {63'd0, bus.sdr_req},   64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rw_idle_ready", {63'd0, bus.cpu_ready}, 64'd1);
        do_read(25'h0012340);
        chk("rw_remiss", {63'd0, bus.cpu_ready}, 64'd0);
        chk("rw_rereq",  {63'd0, bus.sdr_req},   64'd1);
        do_ack(D1);
        chk("rw_dout", {48'd0, bus.cpu_dout}, 64'h1111);
        do_read(25'h0012346);
        chk("rw_hit", {48'd0, bus.cpu_dout}, 64'h4444);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
